// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   state_e   - responder FSM states (RUN, HALT_DUMP, DONE)
//   NOP_INST  - encoding of the MIPS NOP (sll $0,$0,0)
//   be_word() - big-endian word assembly from four bytes (b0 is the lowest
//               address and lands in bits [31:24])
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_DUMP = 2'd1,
    DONE      = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  function automatic logic [31:0] be_word(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2,
                                          input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
// Watches the fetched instruction stream while the CPU is running and decides
// when the run is over.
//   clk, rst    - clock, synchronous active-high reset
//   inst_i      - instruction currently fetched by the CPU
//   en_i        - high while the responder is in RUN; counters freeze otherwise
//   halt_evt_o  - the run ends on this edge (NOP end or watchdog)
//   to_evt_o    - the run ends on this edge because of the watchdog only
// Both events are computed from the counter values this edge will load, so
// the halt is registered by the parent on the very edge the limit is reached.
// -----------------------------------------------------------------------------
module run_monitor
  import dmem_pkg::*;
#(
  parameter int NOP_LIMIT = 9,
  parameter int WATCHDOG  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        en_i,
  output logic        halt_evt_o,
  output logic        to_evt_o
);

  localparam int CW = $clog2(WATCHDOG + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] nop_cnt_q, nop_cnt_d;
  logic [CW-1:0] watch_cnt_q, watch_cnt_d;
  logic          nop_hit, wd_hit;

  // Both counters saturate instead of wrapping.
  always_comb begin
    nop_cnt_d   = nop_cnt_q;
    watch_cnt_d = watch_cnt_q;
    if (en_i) begin
      if (watch_cnt_q != CNT_MAX) watch_cnt_d = watch_cnt_q + 1'b1;
      if (inst_i != NOP_INST) begin
        nop_cnt_d = '0;
      end else if (nop_cnt_q != CNT_MAX) begin
        nop_cnt_d = nop_cnt_q + 1'b1;
      end
    end
  end

  assign nop_hit    = en_i && (nop_cnt_d >= CW'(NOP_LIMIT));
  assign wd_hit     = en_i && (watch_cnt_d >= CW'(WATCHDOG));
  // NOP end wins when both limits are reached together.
  assign halt_evt_o = nop_hit | wd_hit;
  assign to_evt_o   = wd_hit & ~nop_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      nop_cnt_q   <= '0;
      watch_cnt_q <= '0;
    end else begin
      nop_cnt_q   <= nop_cnt_d;
      watch_cnt_q <= watch_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for a single-cycle MIPS core. Byte-addressed,
// big-endian storage with a zero-latency read path. When the program ends
// (run of NOPs) or runs away (watchdog) CPU writes are frozen and the first
// DUMP_WORDS words are streamed out over a valid/ready port.
//   clk, rst             - clock, synchronous active-high reset
//   data_addr/_wr/_wdata - CPU access (address bits [1:0] ignored, upper
//                          bits alias modulo MEM_BYTES)
//   data_rdata           - combinational read of the addressed word
//   inst                 - fetched instruction, monitored only
//   halted, timeout      - run ended / run ended by watchdog
//   dump_valid/_ready    - dump handshake
//   dump_idx, dump_data  - word index and contents being offered
//   done                 - dump finished, sticky until rst
// Storage is never cleared by rst.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES  = 512,
  parameter int NOP_LIMIT  = 9,
  parameter int WATCHDOG   = 500,
  parameter int DUMP_WORDS = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        data_wr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic [31:0] inst,
  output logic        halted,
  output logic        timeout,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [7:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        done
);

  localparam int AW   = $clog2(MEM_BYTES);
  localparam int WI_W = AW - 2;

  if ((MEM_BYTES < 8) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_mem_bytes
    $error("dmem_responder: MEM_BYTES must be a power of two and a multiple of 4");
  end
  if ((DUMP_WORDS < 1) || (DUMP_WORDS * 4 > MEM_BYTES) || (DUMP_WORDS > 256)) begin : g_bad_dump_words
    $error("dmem_responder: DUMP_WORDS must fit in storage and in the 8-bit index");
  end

  logic [7:0] mem_q [MEM_BYTES];

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;
  logic        dump_valid_q, dump_valid_d;
  logic [7:0]  dump_idx_q, dump_idx_d;
  logic        done_q, done_d;

  logic            halt_evt, to_evt;
  logic            run_en, wr_en;
  logic [WI_W-1:0] cpu_wi, dump_wi;
  logic            unused_addr;

  assign cpu_wi      = data_addr[AW-1:2];
  assign dump_wi     = WI_W'(dump_idx_q);
  assign unused_addr = ^{data_addr[31:AW], data_addr[1:0]};

  assign run_en = (state_q == RUN);
  assign wr_en  = !rst && data_wr && run_en;

  run_monitor #(
    .NOP_LIMIT (NOP_LIMIT),
    .WATCHDOG  (WATCHDOG)
  ) u_run_monitor (
    .clk        (clk),
    .rst        (rst),
    .inst_i     (inst),
    .en_i       (run_en),
    .halt_evt_o (halt_evt),
    .to_evt_o   (to_evt)
  );

  // Read-before-write: a same-cycle read of the written word sees old data.
  assign data_rdata = be_word(mem_q[{cpu_wi, 2'd0}], mem_q[{cpu_wi, 2'd1}],
                              mem_q[{cpu_wi, 2'd2}], mem_q[{cpu_wi, 2'd3}]);
  assign dump_data  = be_word(mem_q[{dump_wi, 2'd0}], mem_q[{dump_wi, 2'd1}],
                              mem_q[{dump_wi, 2'd2}], mem_q[{dump_wi, 2'd3}]);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{cpu_wi, 2'd0}] <= data_wdata[31:24];
      mem_q[{cpu_wi, 2'd1}] <= data_wdata[23:16];
      mem_q[{cpu_wi, 2'd2}] <= data_wdata[15:8];
      mem_q[{cpu_wi, 2'd3}] <= data_wdata[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    done_d       = done_q;
    case (state_q)
      RUN: begin
        if (halt_evt) begin
          state_d      = HALT_DUMP;
          halted_d     = 1'b1;
          timeout_d    = to_evt;
          dump_idx_d   = 8'd0;
          dump_valid_d = 1'b1;
        end
      end
      HALT_DUMP: begin
        if (dump_valid_q && dump_ready) begin
          dump_idx_d = dump_idx_q + 8'd1;
          if (dump_idx_q == 8'(DUMP_WORDS - 1)) begin
            dump_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      done_q       <= done_d;
    end
  end

  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign done       = done_q;

endmodule
